seg_scan_decoder: RTL and testbench
===================================

// Module: seg_scan_decoder
// PURPOSE
//  Receive side of the multiplexed 7-segment interface: samples the anode/cathode
//  lines, decodes each scanned digit back to a hex value, and presents a complete
//  4-digit frame on a valid/ready handshake. Used as a display monitor/scoreboard
//  for self-checking benches and for on-board readback of score/stopwatch digits.
// PARAMETERS
//  STABLE_CYCLES  16       consecutive identical sync'd samples before a digit is captured (>=2)
//  FRAME_TIMEOUT  1048576  cycles without a completed frame before stale asserts
// PORTS
//  clk          in   1  system clock
//  rst          in   1  asynchronous reset, active-low
//  anode        in   4  digit enables, active-low; 4'b1110 = digit0 (rightmost) .. 4'b0111 = digit3
//  cathode      in   7  segments, active-low; bit0=a .. bit6=g
//  frame_ready  in   1  consumer accepts frame when high with frame_valid
//  frame_valid  out  1  digit*/blank/invalid hold a complete frame
//  digit0..3    out  4  decoded hex value per digit position
//  blank        out  4  per digit: all segments off (7'h7F)
//  invalid      out  4  per digit: pattern is neither hex glyph nor blank
//  overrun      out  1  sticky: a completed frame was dropped
//  stale        out  1  no frame completed within FRAME_TIMEOUT cycles
// BEHAVIOUR
//  Reset (rst=0, async): digits=0, blank=4'hF, invalid=0, frame_valid=0, overrun=0,
//   stale=0; sync flops, stability counter, seen mask, slot registers cleared.
//  Input path: anode and cathode each pass a 2-flop synchronizer.
//  Stability: sampled {anode,cathode} compared to previous sample each cycle.
//   - Legal anode = exactly one bit low. 4'hF (dark) or >1 bit low = illegal.
//   - Change or illegal anode -> counter=0, captured=0.
//   - Equal and legal -> counter increments, saturating at STABLE_CYCLES-1.
//   - Counter hits STABLE_CYCLES-1 with captured=0 -> capture once into the slot
//     of the enabled digit, set captured=1 and seen[i]=1. Repeat capture of a digit
//     already in seen overwrites its slot (latest wins).
//  Decode (combinational at capture): standard active-low hex glyphs 0-9,A,b,C,d,E,F
//   (identical to the team's SevenSegment encoder table) -> value, blank=0, invalid=0;
//   7'h7F -> value 0, blank=1; any other pattern -> value 0, invalid=1.
//  Frame completion: cycle after seen becomes 4'hF:
//   - If !frame_valid or frame_ready: slots -> outputs, frame_valid=1, seen=0.
//   - Else (held, not accepted): frame dropped, overrun=1 (sticky until reset),
//     outputs unchanged, seen=0.
//   - Completion coinciding with frame_ready acceptance loads the new frame;
//     frame_valid stays 1.
//  Handshake: frame_valid&&frame_ready with no completion -> frame_valid=0 next
//   cycle; outputs hold last values. Outputs never change while frame_valid=1 and
//   frame_ready=0.
//  Latency: last stable input edge to frame_valid = 2 + STABLE_CYCLES + 1 cycles.
//  Stale: timeout counter clears on each frame completion (loaded or dropped),
//   else increments, saturating at FRAME_TIMEOUT; stale=1 while saturated.
//  Scan glitches shorter than STABLE_CYCLES never capture; reset mid-frame
//   discards partial seen mask and slots.
// TESTING
//  1. Scan 1,2,3,4 (digit3..0), 40 cycles each, frame_ready=1 -> frame_valid pulse,
//     digit3..0=1,2,3,4, blank=0, invalid=0.
//  2. Digit2 cathode 7'h7F, digit1 7'h55 -> blank=4'b0100, invalid=4'b0010,
//     digit2=digit1=0.
//  3. frame_ready=0, scan two full frames -> first frame held unchanged, overrun=1.
//  4. 10-cycle glitch (digit0 shows 8 between 5's) -> digit0 stays 5 in next frame;
//     anode=4'b1100 for 40 cycles -> no capture.
//  5. Stop scanning (anode=4'hF) for FRAME_TIMEOUT cycles -> stale=1; one full frame
//     -> stale=0.
//  6. Assert rst with seen=4'b0111 -> all outputs at reset values; completing
//     frame requires all four digits again.

Source files
------------

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: receive side of a multiplexed 4-digit 7-segment bus.
// Synchronises anode/cathode, waits for each scanned digit to be stable,
// decodes the glyph back to hex and hands out whole frames on valid/ready.
module seg_scan_decoder #(
  parameter int STABLE_CYCLES = 16,
  parameter int FRAME_TIMEOUT = 1048576
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] anode,
  input  logic [6:0] cathode,
  input  logic       frame_ready,
  output logic       frame_valid,
  output logic [3:0] digit0,
  output logic [3:0] digit1,
  output logic [3:0] digit2,
  output logic [3:0] digit3,
  output logic [3:0] blank,
  output logic [3:0] invalid,
  output logic       overrun,
  output logic       stale
);

  localparam int CW = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
  localparam int TW = $clog2(FRAME_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);
  localparam logic [TW-1:0] TMO     = TW'(FRAME_TIMEOUT);

  logic [3:0]      an_s1, an_s2;
  logic [6:0]      ca_s1, ca_s2;
  logic [10:0]     prev;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic            captured;
  logic            legal, stable, capture, complete;
  logic [3:0]      sel, seen, seen_nxt;
  logic [3:0]      dec_val;
  logic            dec_blank, dec_inv;
  logic [3:0][3:0] slot_val, out_val;
  logic [3:0]      slot_blank, slot_inv;
  logic [TW-1:0]   tcnt;

  // two-flop synchronisers on both buses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      an_s1 <= '0; an_s2 <= '0;
      ca_s1 <= '0; ca_s2 <= '0;
    end else begin
      an_s1 <= anode;   an_s2 <= an_s1;
      ca_s1 <= cathode; ca_s2 <= ca_s1;
    end
  end

  // legality, stability count and one-shot capture strobe for the current dwell
  always_comb begin
    legal = 1'b0;
    case (an_s2)
      4'b1110, 4'b1101, 4'b1011, 4'b0111: legal = 1'b1;
      default:                            legal = 1'b0;
    endcase
    sel     = ~an_s2;
    stable  = legal && ({an_s2, ca_s2} == prev);
    cnt_nxt = '0;
    if (stable) cnt_nxt = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);
    // capture on the same edge the count reaches its top, so a dwell of
    // exactly STABLE_CYCLES cycles is enough
    capture  = stable && !captured && (cnt_nxt == CNT_MAX);
    complete = (seen == 4'hF);
    seen_nxt = (complete ? 4'h0 : seen) | (capture ? sel : 4'h0);
  end

  // active-low glyph decode of the sampled cathode
  always_comb begin
    dec_val   = 4'h0;
    dec_blank = 1'b0;
    dec_inv   = 1'b0;
    case (ca_s2)
      7'h40: dec_val = 4'h0;
      7'h79: dec_val = 4'h1;
      7'h24: dec_val = 4'h2;
      7'h30: dec_val = 4'h3;
      7'h19: dec_val = 4'h4;
      7'h12: dec_val = 4'h5;
      7'h02: dec_val = 4'h6;
      7'h78: dec_val = 4'h7;
      7'h00: dec_val = 4'h8;
      7'h10: dec_val = 4'h9;
      7'h08: dec_val = 4'hA;
      7'h03: dec_val = 4'hB;
      7'h46: dec_val = 4'hC;
      7'h21: dec_val = 4'hD;
      7'h06: dec_val = 4'hE;
      7'h0E: dec_val = 4'hF;
      7'h7F: dec_blank = 1'b1;
      default: dec_inv = 1'b1;
    endcase
  end

  // stability tracking and seen mask
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev     <= '0;
      cnt      <= '0;
      captured <= 1'b0;
      seen     <= '0;
    end else begin
      prev     <= {an_s2, ca_s2};
      cnt      <= cnt_nxt;
      captured <= stable && (captured || capture);
      seen     <= seen_nxt;
    end
  end

  // one slot per digit position; a repeat capture overwrites (latest wins)
  for (genvar i = 0; i < 4; i++) begin : g_slot
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        slot_val[i]   <= '0;
        slot_blank[i] <= 1'b0;
        slot_inv[i]   <= 1'b0;
      end else if (capture && sel[i]) begin
        slot_val[i]   <= dec_val;
        slot_blank[i] <= dec_blank;
        slot_inv[i]   <= dec_inv;
      end
    end
  end

  // frame hand-off: load when the output register is free or being accepted
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_valid <= 1'b0;
      out_val     <= '0;
      blank       <= 4'hF;
      invalid     <= 4'h0;
      overrun     <= 1'b0;
    end else if (complete) begin
      if (!frame_valid || frame_ready) begin
        frame_valid <= 1'b1;
        out_val     <= slot_val;
        blank       <= slot_blank;
        invalid     <= slot_inv;
      end else begin
        overrun     <= 1'b1;
      end
    end else if (frame_valid && frame_ready) begin
      frame_valid <= 1'b0;
    end
  end

  // frame watchdog, cleared by any completion whether loaded or dropped
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)            tcnt <= '0;
    else if (complete)   tcnt <= '0;
    else if (tcnt != TMO) tcnt <= tcnt + TW'(1);
  end

  assign stale  = (tcnt == TMO);
  assign digit0 = out_val[0];
  assign digit1 = out_val[1];
  assign digit2 = out_val[2];
  assign digit3 = out_val[3];

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Bench for seg_scan_decoder: table of whole-frame vectors, hand sequences for
// overrun/glitch/dwell-boundary/stale/reset, and a random scan checked against
// a dwell-level reference model.
module tb_seg_scan_decoder;
  localparam int S  = 16;
  localparam int FT = 2000;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] anode;
  logic [6:0] cathode;
  logic       frame_ready;
  logic       frame_valid, overrun, stale;
  logic [3:0] digit0, digit1, digit2, digit3, blank, invalid;

  always #5 clk = ~clk;

  seg_scan_decoder #(.STABLE_CYCLES(S), .FRAME_TIMEOUT(FT)) dut (
    .clk(clk), .rst(rst), .anode(anode), .cathode(cathode),
    .frame_ready(frame_ready), .frame_valid(frame_valid),
    .digit0(digit0), .digit1(digit1), .digit2(digit2), .digit3(digit3),
    .blank(blank), .invalid(invalid), .overrun(overrun), .stale(stale)
  );

  int nvec = 0;
  int nerr = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // active-low hex glyphs, bit0=a .. bit6=g
  logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // frame word: {d3,d2,d1,d0, blank[3:0], invalid[3:0]}
  function automatic logic [23:0] out_word();
    return {digit3, digit2, digit1, digit0, blank, invalid};
  endfunction

  // frame monitor / scoreboard
  logic [23:0] last_f;
  int          fcount = 0;
  bit          use_sb = 0;
  logic [23:0] exp_q [$];

  always @(negedge clk) begin
    if (rst && frame_valid && frame_ready) begin
      fcount++;
      last_f = out_word();
      if (use_sb) begin
        if (exp_q.size() == 0) check("sb_extra_frame", 1, 0);
        else check("sb_frame", last_f, exp_q.pop_front());
      end
    end
  end

  task automatic hold(input logic [3:0] a, input logic [6:0] c, input int d);
    anode   = a;
    cathode = c;
    repeat (d) @(posedge clk);
    #1;
  endtask

  task automatic flush(input int d);
    hold(4'hF, 7'h7F, d);
  endtask

  task automatic scan(input logic [6:0] c3, c2, c1, c0, input int d);
    hold(4'b0111, c3, d);
    hold(4'b1011, c2, d);
    hold(4'b1101, c1, d);
    hold(4'b1110, c0, d);
    flush(6);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_fv"},   frame_valid, 0);
    check({tag, "_word"}, out_word(), {16'h0, 4'hF, 4'h0});
    check({tag, "_ovr"},  overrun, 0);
    check({tag, "_stale"}, stale, 0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    flush(3);
    rst = 1'b1;
    flush(2);
  endtask

  // reference model: a dwell of a legal digit lasting >= S cycles captures
  // once; adjacent identical dwells are one dwell
  function automatic logic [5:0] ref_decode(input logic [6:0] c);
    for (int g = 0; g < 16; g++) if (glyph[g] == c) return {g[3:0], 2'b00};
    if (c == 7'h7F) return 6'b0000_10;
    return 6'b0000_01;
  endfunction

  logic [10:0] m_key;
  int          m_len;
  bit          m_cap;
  logic [3:0]  m_seen;
  logic [5:0]  m_slot [4];

  task automatic model_hold(input logic [3:0] a, input logic [6:0] c, input int d);
    int k;
    k = -1;
    if ({a, c} == m_key) m_len += d;
    else begin m_key = {a, c}; m_len = d; m_cap = 0; end
    for (int i = 0; i < 4; i++) if (a == ~(4'b1 << i)) k = i;
    if (k >= 0 && !m_cap && m_len >= S) begin
      m_cap     = 1;
      m_slot[k] = ref_decode(c);
      m_seen[k] = 1'b1;
      if (m_seen == 4'hF) begin
        exp_q.push_back({m_slot[3][5:2], m_slot[2][5:2], m_slot[1][5:2], m_slot[0][5:2],
                         m_slot[3][1], m_slot[2][1], m_slot[1][1], m_slot[0][1],
                         m_slot[3][0], m_slot[2][0], m_slot[1][0], m_slot[0][0]});
        m_seen = 4'h0;
      end
    end
  endtask

  typedef struct {
    logic [6:0]  c3, c2, c1, c0;
    logic [15:0] val;
    logic [3:0]  blk, inv;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int f0;
    vecs[0] = '{7'h79, 7'h24, 7'h30, 7'h19, 16'h1234, 4'b0000, 4'b0000};
    vecs[1] = '{7'h12, 7'h7F, 7'h55, 7'h10, 16'h5009, 4'b0100, 4'b0010};
    vecs[2] = '{7'h08, 7'h03, 7'h46, 7'h21, 16'hABCD, 4'b0000, 4'b0000};
    vecs[3] = '{7'h06, 7'h0E, 7'h40, 7'h00, 16'hEF08, 4'b0000, 4'b0000};
    vecs[4] = '{7'h02, 7'h78, 7'h7F, 7'h7E, 16'h6700, 4'b0010, 4'b0001};

    rst = 1'b0; anode = 4'hF; cathode = 7'h7F; frame_ready = 1'b1;
    #1;
    flush(3);
    check_reset_vals("reset");
    rst = 1'b1;
    flush(2);

    // table of whole frames, consumer always ready
    for (int v = 0; v < 5; v++) begin
      f0 = fcount;
      scan(vecs[v].c3, vecs[v].c2, vecs[v].c1, vecs[v].c0, 40);
      check($sformatf("vec%0d_count", v), fcount - f0, 1);
      check($sformatf("vec%0d_frame", v), last_f, {vecs[v].val, vecs[v].blk, vecs[v].inv});
      check($sformatf("vec%0d_fv_drop", v), frame_valid, 0);
    end

    // overrun: consumer stalled across two frames
    do_reset();
    frame_ready = 1'b0;
    scan(7'h79, 7'h24, 7'h30, 7'h19, 40);
    check("ovr_fv1", frame_valid, 1);
    check("ovr_word1", out_word(), {16'h1234, 8'h00});
    check("ovr_flag1", overrun, 0);
    scan(7'h08, 7'h03, 7'h46, 7'h21, 40);
    check("ovr_fv2", frame_valid, 1);
    check("ovr_word_held", out_word(), {16'h1234, 8'h00});
    check("ovr_flag2", overrun, 1);
    frame_ready = 1'b1;
    flush(1);
    check("ovr_fv_accept", frame_valid, 0);
    check("ovr_word_after", out_word(), {16'h1234, 8'h00});
    check("ovr_sticky", overrun, 1);

    // glitch on digit0 and an illegal two-digit anode
    do_reset();
    f0 = fcount;
    hold(4'b0111, glyph[1], 40);
    hold(4'b1011, glyph[2], 40);
    hold(4'b1101, glyph[3], 40);
    hold(4'b1110, glyph[8], 10);
    hold(4'b1110, glyph[5], 40);
    flush(6);
    check("glitch_count", fcount - f0, 1);
    check("glitch_frame", last_f, {16'h1235, 8'h00});
    f0 = fcount;
    hold(4'b0111, glyph[4], 40);
    hold(4'b1011, glyph[5], 40);
    hold(4'b1101, glyph[6], 40);
    hold(4'b1100, glyph[8], 40);
    flush(20);
    check("illegal_anode_nocap", fcount - f0, 0);
    hold(4'b1110, glyph[5], 40);
    flush(6);
    check("illegal_then_count", fcount - f0, 1);
    check("illegal_then_frame", last_f, {16'h4565, 8'h00});

    // dwell boundary: S-1 cycles never captures, S cycles does
    f0 = fcount;
    hold(4'b0111, glyph[9], 40);
    hold(4'b1011, glyph[8], 40);
    hold(4'b1101, glyph[7], 40);
    hold(4'b1110, glyph[7], S - 1);
    flush(20);
    check("dwell_short", fcount - f0, 0);
    hold(4'b1110, glyph[7], S);
    flush(10);
    check("dwell_exact", fcount - f0, 1);
    check("dwell_frame", last_f, {16'h9877, 8'h00});

    // stale watchdog
    flush(FT / 2);
    check("stale_early", stale, 0);
    flush(FT / 2 + 20);
    check("stale_set", stale, 1);
    scan(7'h79, 7'h79, 7'h79, 7'h79, 40);
    check("stale_clear", stale, 0);

    // reset with three digits already seen
    hold(4'b1011, glyph[2], 40);
    hold(4'b1101, glyph[3], 40);
    hold(4'b1110, glyph[4], 40);
    rst = 1'b0;
    flush(3);
    check_reset_vals("midrst");
    rst = 1'b1;
    flush(2);
    f0 = fcount;
    hold(4'b0111, glyph[1], 40);
    flush(20);
    check("midrst_partial", fcount - f0, 0);
    scan(glyph[1], glyph[2], glyph[3], glyph[4], 40);
    check("midrst_full", fcount - f0, 1);
    check("midrst_frame", last_f, {16'h1234, 8'h00});

    // random scan against the dwell-level model
    do_reset();
    m_key = 11'h7FF; m_len = 0; m_cap = 0; m_seen = 4'h0;
    for (int i = 0; i < 4; i++) m_slot[i] = 6'h0;
    model_hold(4'hF, 7'h7F, 2);
    exp_q.delete();
    use_sb = 1;
    for (int n = 0; n < 160; n++) begin
      logic [3:0] a;
      logic [6:0] c;
      int r, d;
      r = $urandom_range(0, 9);
      if (r < 8)       a = ~(4'b1 << $urandom_range(0, 3));
      else if (r == 8) a = 4'hF;
      else             a = 4'($urandom);
      r = $urandom_range(0, 9);
      if (r < 7)       c = glyph[$urandom_range(0, 15)];
      else if (r == 7) c = 7'h7F;
      else             c = 7'($urandom);
      d = $urandom_range(S - 3, S + 8);
      model_hold(a, c, d);
      hold(a, c, d);
    end
    model_hold(4'hF, 7'h7F, 30);
    flush(30);
    check("sb_pending", exp_q.size(), 0);
    use_sb = 0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
